uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Parametrised UART transmit framer, successor to the combinational parity generator. Accepts a DATA_W-bit word over a valid/ready handshake and serialises it on tx: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. The bit period is timed internally. Parity accumulates serially as bits are shifted out. Sits between the transmit input register/FIFO and the pad.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
data_in  input  DATA_W  word to transmit; sampled only on an accept.
data_valid  input  1  data_in is valid.
data_ready  output  1  framer can accept; high only in IDLE.
parity_type  input  3  000 none, 001 odd, 010 even, 011 mark (1), 100 space (0), 101..111 none.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx  output  1  serial line; idle high.
busy  output  1  high from the accept cycle until the end of the last stop bit.
done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; tx = 1, busy = 0, done = 0, data_ready = 1; bit counter, clock counter and parity accumulator cleared. Reset mid-frame aborts the frame; tx returns to 1 asynchronously.
- Accept: data_valid & data_ready at a clock edge. data_in, parity_type and stop2 are latched at that edge. Later changes to these inputs do not affect the frame in flight.
- Latency: tx drives the start bit (0) starting in the cycle after the accept. Each bit is held for exactly CLKS_PER_BIT cycles.
- States:
  - IDLE: tx = 1. Go to START on accept.
  - START: tx = 0. Go to DATA after one bit period.
  - DATA: tx = shift_reg[0]. Each bit period, shift right and XOR the bit into the parity accumulator. After DATA_W bits, go to PARITY if the latched type is 001..100, otherwise to STOP.
  - PARITY: tx = parity bit.
    - odd: inverse of accumulated XOR.
    - even: accumulated XOR.
    - mark: 1.
    - space: 0.
  - STOP: tx = 1 for one bit period, or two if stop2 was latched as 1. In the final cycle, done = 1; next state is IDLE.
- Frame length in cycles = CLKS_PER_BIT * (1 + DATA_W + P + S), where P = 1 if parity is enabled, else 0, and S = number of stop bits.
- Back-to-back: data_ready rises in the cycle after done. A word accepted in that cycle starts its start bit one cycle later. Minimum gap between frames is 1 idle-high cycle.
- data_valid while busy is ignored; the word is not lost, because ready is low and the source holds it.
- Outputs tx, busy and done are registered, with no combinational path from inputs. data_ready is decoded from state only.
- Counter widths: clock counter $clog2(CLKS_PER_BIT); bit counter $clog2(DATA_W+1). Neither counter wraps within a state.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input break_req (1 bit). If break_req is high while in IDLE, the block enters BREAK: tx = 0, data_ready = 0, busy = 1. It stays in BREAK while break_req is high, then returns to IDLE with tx = 1 on the cycle after break_req falls. break_req asserted mid-frame is deferred until the frame completes.
- Undefined: no break_req port and no BREAK state; behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE).
  - The framer state enum.
  - Default DATA_W and CLKS_PER_BIT constants.
- One sub-module: uart_bit_timer. It takes CLKS_PER_BIT, counts while enabled, and emits bit_end in the last cycle of each bit period. It restarts on enable rising.

Test Plan:
- CLKS_PER_BIT=4, DATA_W=8, data 0xA5, even, stop2=0 -> tx 0,1,0,1,0,0,1,0,1, parity 0, stop 1; 44 busy cycles; done once.
- Same word with odd / mark / space -> parity bit 1 / 1 / 0.
- DATA_W=7, data 0x7F, none, stop2=1 -> 0, seven 1s, 1, 1; 40 cycles; no parity slot.
- data_valid held high with two words (0x00 then 0xFF), none -> second start bit exactly 2 cycles after the first frame's done; data_ready low throughout each frame.
- Reset asserted in the 3rd data bit -> tx = 1, busy = 0, data_ready = 1 immediately; the next accepted frame is correct.
- With UART_TX_BREAK_EN: break_req high for 20 cycles in IDLE -> tx low 20 cycles, data_ready 0; break_req raised mid-frame -> break starts only after done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit framer: parity selections, framer
// states and default frame geometry. Build option: UART_TX_BREAK_EN.
package uart_pkg;

   localparam logic [2:0] PAR_NONE  = 3'b000;
   localparam logic [2:0] PAR_ODD   = 3'b001;
   localparam logic [2:0] PAR_EVEN  = 3'b010;
   localparam logic [2:0] PAR_MARK  = 3'b011;
   localparam logic [2:0] PAR_SPACE = 3'b100;

   localparam int DEFAULT_DATA_W       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef UART_TX_BREAK_EN
      , ST_BREAK
`endif
   } tx_state_t;

   // Encodings 101..111 are treated as "no parity slot".
   function automatic logic parity_enabled(input logic [2:0] ptype);
      return (ptype == PAR_ODD) || (ptype == PAR_EVEN) ||
             (ptype == PAR_MARK) || (ptype == PAR_SPACE);
   endfunction

   function automatic logic parity_bit(input logic [2:0] ptype, input logic xor_acc);
      case (ptype)
         PAR_ODD:  return ~xor_acc;
         PAR_EVEN: return xor_acc;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_framer_timer.sv
// Bit-period timer: counts clk cycles while enabled and flags the last cycle
// (bit_end) and the one before it (bit_almost_end) of every bit period.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bit_end,
   output logic bit_almost_end
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   // Held at zero while disabled, so every enable rising starts a fresh period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_end        = en && (cnt == LAST);
   assign bit_almost_end = en && (cnt == PRE_LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits. Build option UART_TX_BREAK_EN adds a break_req input.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [2:0]        parity_type,
   input  logic              stop2,
`ifdef UART_TX_BREAK_EN
   input  logic              break_req,
`endif
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shift_reg;
   logic [BIT_W-1:0]  bit_cnt;
   logic              par_acc;
   logic [2:0]        par_q;
   logic              stop2_q;

   logic timer_en;
   logic bit_end;
   logic bit_almost_end;
   logic last_data;
   logic last_stop;

   always_comb begin
      timer_en = (state != ST_IDLE);
`ifdef UART_TX_BREAK_EN
      if (state == ST_BREAK) timer_en = 1'b0;
`endif
   end

   assign last_data  = (bit_cnt == BIT_W'(DATA_W - 1));
   assign last_stop  = (bit_cnt == BIT_W'(stop2_q));
   assign data_ready = (state == ST_IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .en            (timer_en),
      .bit_end       (bit_end),
      .bit_almost_end(bit_almost_end)
   );

   // tx is loaded with the value of the state being entered, so the line
   // changes on the same edge as the state and stays glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         par_acc   <= 1'b0;
         par_q     <= PAR_NONE;
         stop2_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // An offered word wins over a break so a handshake never drops data.
               if (data_valid) begin
                  state     <= ST_START;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  shift_reg <= data_in;
                  par_q     <= parity_type;
                  stop2_q   <= stop2;
                  par_acc   <= 1'b0;
                  bit_cnt   <= '0;
               end
`ifdef UART_TX_BREAK_EN
               else if (break_req) begin
                  state <= ST_BREAK;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
`endif
            end
            ST_START: begin
               if (bit_end) begin
                  state <= ST_DATA;
                  tx    <= shift_reg[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  shift_reg <= shift_reg >> 1;
                  par_acc   <= par_acc ^ shift_reg[0];
                  if (last_data) begin
                     bit_cnt <= '0;
                     if (parity_enabled(par_q)) begin
                        state <= ST_PARITY;
                        tx    <= parity_bit(par_q, par_acc ^ shift_reg[0]);
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift_reg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     state   <= ST_IDLE;
                     busy    <= 1'b0;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  tx <= 1'b1;
               end else if (bit_almost_end && last_stop) begin
                  done <= 1'b1;
               end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
               if (!break_req) begin
                  state <= ST_IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer (8-bit and 7-bit instances,
// CLKS_PER_BIT = 4). Break tests are compiled in with UART_TX_BREAK_EN.
module tb_uart_tx_framer;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic [7:0] data8;
   logic [6:0] data7;
   logic       valid8, valid7;
   logic [2:0] parity_type;
   logic       stop2;
   logic       break_req;
   logic       tx8, busy8, done8, ready8;
   logic       tx7, busy7, done7, ready7;

   logic       tx_m, busy_m, done_m, ready_m;
   int         sel;

   int         checks, passes, fails;
   logic       samp [0:255];
   int         n_cyc, n_done, done_idx, ready_hi;

   uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data8),
      .data_valid (valid8),
      .data_ready (ready8),
      .parity_type(parity_type),
      .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
      .break_req  (break_req),
`endif
      .tx         (tx8),
      .busy       (busy8),
      .done       (done8)
   );

   uart_tx_framer #(.DATA_W(7), .CLKS_PER_BIT(CPB)) dut7 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data7),
      .data_valid (valid7),
      .data_ready (ready7),
      .parity_type(parity_type),
      .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
      .break_req  (1'b0),
`endif
      .tx         (tx7),
      .busy       (busy7),
      .done       (done7)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      tx_m    = (sel == 1) ? tx7    : tx8;
      busy_m  = (sel == 1) ? busy7  : busy8;
      done_m  = (sel == 1) ? done7  : done8;
      ready_m = (sel == 1) ? ready7 : ready8;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one word and let it be accepted; returns in the first start-bit cycle.
   task automatic applyStimulus(input int which, input logic [7:0] d, input logic [2:0] p, input logic s2);
      sel         = which;
      parity_type = p;
      stop2       = s2;
      if (which == 1) begin
         data7  = d[6:0];
         valid7 = 1'b1;
      end else begin
         data8  = d;
         valid8 = 1'b1;
      end
      step();
      valid8      = 1'b0;
      valid7      = 1'b0;
      data8       = ~d;
      data7       = ~d[6:0];
      parity_type = 3'b111;
      stop2       = ~s2;
   endtask

   task automatic captureFrame();
      n_cyc    = 0;
      n_done   = 0;
      done_idx = -1;
      ready_hi = 0;
      while (busy_m && n_cyc < 200) begin
         samp[n_cyc] = tx_m;
         if (done_m) begin
            n_done++;
            done_idx = n_cyc;
         end
         if (ready_m) ready_hi++;
         n_cyc++;
         step();
      end
   endtask

   task automatic checkFrame(input string tag, input logic [15:0] exp_bits, input int nbits, input int cycles);
      logic [15:0] obs;
      int unstable;
      obs = '0;
      unstable = 0;
      for (int k = 0; k < nbits; k++)
         obs[k] = (k * CPB < n_cyc) ? samp[k * CPB] : 1'bx;
      for (int i = 0; i < n_cyc; i++)
         if (samp[i] !== samp[(i / CPB) * CPB]) unstable++;
      checkOutput({tag, " bits"},        32'(obs),      32'(exp_bits));
      checkOutput({tag, " busy cycles"}, 32'(n_cyc),    32'(cycles));
      checkOutput({tag, " bit stable"},  32'(unstable), 32'd0);
      checkOutput({tag, " done count"},  32'(n_done),   32'd1);
      checkOutput({tag, " done index"},  32'(done_idx), 32'(cycles - 1));
      checkOutput({tag, " ready low"},   32'(ready_hi), 32'd0);
      checkOutput({tag, " post tx"},     32'(tx_m),     32'd1);
      checkOutput({tag, " post ready"},  32'(ready_m),  32'd1);
      checkOutput({tag, " post done"},   32'(done_m),   32'd0);
   endtask

   initial begin
      checks = 0;
      passes = 0;
      fails  = 0;
      sel    = 0;
      rst    = 1'b1;
      data8  = '0;
      data7  = '0;
      valid8 = 1'b0;
      valid7 = 1'b0;
      parity_type = 3'b000;
      stop2       = 1'b0;
      break_req   = 1'b0;
      step();
      step();

      // Reset state of both instances
      checkOutput("rst tx8",    32'(tx8),    32'd1);
      checkOutput("rst busy8",  32'(busy8),  32'd0);
      checkOutput("rst done8",  32'(done8),  32'd0);
      checkOutput("rst ready8", 32'(ready8), 32'd1);
      checkOutput("rst tx7",    32'(tx7),    32'd1);
      checkOutput("rst ready7", 32'(ready7), 32'd1);
      rst = 1'b0;
      step();

      // 0xA5 with each parity flavour: start, A5 LSB first, parity, stop
      applyStimulus(0, 8'hA5, 3'b010, 1'b0);
      captureFrame();
      checkFrame("A5 even", 16'b1_0_10100101_0, 11, 44);
      applyStimulus(0, 8'hA5, 3'b001, 1'b0);
      captureFrame();
      checkFrame("A5 odd", 16'b1_1_10100101_0, 11, 44);
      applyStimulus(0, 8'hA5, 3'b011, 1'b0);
      captureFrame();
      checkFrame("A5 mark", 16'b1_1_10100101_0, 11, 44);
      applyStimulus(0, 8'hA5, 3'b100, 1'b0);
      captureFrame();
      checkFrame("A5 space", 16'b1_0_10100101_0, 11, 44);

      // 7-bit word, no parity, two stop bits
      applyStimulus(1, 8'h7F, 3'b000, 1'b1);
      captureFrame();
      checkFrame("7F w7 stop2", 16'b11_1111111_0, 10, 40);
      sel = 0;

      // Back-to-back with data_valid held high
      data8       = 8'h00;
      parity_type = 3'b000;
      stop2       = 1'b0;
      valid8      = 1'b1;
      step();
      data8 = 8'hFF;
      captureFrame();
      checkFrame("b2b first", 16'b1_00000000_0, 10, 40);
      step();
      valid8 = 1'b0;
      checkOutput("b2b start gap tx",   32'(tx8),   32'd0);
      checkOutput("b2b start gap busy", 32'(busy8), 32'd1);
      captureFrame();
      checkFrame("b2b second", 16'b1_11111111_0, 10, 40);

      // Reset in the 3rd data bit aborts the frame asynchronously
      applyStimulus(0, 8'h00, 3'b010, 1'b0);
      repeat (13) step();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort tx",    32'(tx8),    32'd1);
      checkOutput("abort busy",  32'(busy8),  32'd0);
      checkOutput("abort ready", 32'(ready8), 32'd1);
      step();
      rst = 1'b0;
      step();
      applyStimulus(0, 8'h3C, 3'b001, 1'b0);
      captureFrame();
      checkFrame("3C odd after abort", 16'b1_1_00111100_0, 11, 44);

`ifdef UART_TX_BREAK_EN
      begin
         int low_cnt;
         low_cnt   = 0;
         break_req = 1'b1;
         for (int i = 0; i < 20; i++) begin
            step();
            if (tx8 == 1'b0 && ready8 == 1'b0 && busy8 == 1'b1) low_cnt++;
         end
         break_req = 1'b0;
         step();
         checkOutput("break low cycles", 32'(low_cnt), 32'd20);
         checkOutput("break end tx",     32'(tx8),     32'd1);
         checkOutput("break end ready",  32'(ready8),  32'd1);
         step();

         applyStimulus(0, 8'hA5, 3'b010, 1'b0);
         break_req = 1'b1;
         captureFrame();
         checkFrame("A5 even with break pending", 16'b1_0_10100101_0, 11, 44);
         step();
         checkOutput("deferred break tx",    32'(tx8),    32'd0);
         checkOutput("deferred break ready", 32'(ready8), 32'd0);
         break_req = 1'b0;
         step();
         checkOutput("deferred break end tx", 32'(tx8), 32'd1);
      end
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
